// File: rtl/counter_share_pkg.sv
// Shared state encoding and default sizes for the counter-sharing controller.
// Build option: COUNTER_SHARE_FIXED_PRIO_EN selects fixed-priority arbitration.
package counter_share_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter_n.sv
// One-hot winner picker: round-robin from ptr+1, or lowest index when
// COUNTER_SHARE_FIXED_PRIO_EN is defined.
module rr_arbiter_n
    import counter_share_pkg::*;
#(
    parameter int N  = DEF_N_REQ,
    parameter int PW = $clog2(DEF_N_REQ)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);

    logic found;
    int   idx;

`ifdef COUNTER_SHARE_FIXED_PRIO_EN
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                win[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`else
    // Search starts just past the last owner so it goes to the back of the line.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/counter_share_ctrl.sv
// Time-shares one external counter between requesters for delay intervals.
// Build option: COUNTER_SHARE_FIXED_PRIO_EN drops the round-robin pointer.
module counter_share_ctrl
    import counter_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*CNT_W-1:0] len,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic               cnt_clr,
    output logic               cnt_en,
    input  logic [CNT_W-1:0]   cnt_q
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t           state;
    logic [CNT_W-1:0] len_l;
    logic [CNT_W-1:0] len_w;
    logic [N_REQ-1:0] win;
    logic [PTR_W-1:0] widx;
    logic [PTR_W-1:0] ptr;
    logic             own_req;

`ifdef COUNTER_SHARE_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [PTR_W-1:0] rr_ptr;
    assign ptr = rr_ptr;
`endif

    rr_arbiter_n #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

    always_comb begin
        widx  = '0;
        len_w = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                widx  = PTR_W'(i);
                len_w = len[i*CNT_W +: CNT_W];
            end
        end
    end

    assign own_req = |(req & gnt);
    assign cnt_clr = (state == CLR);
    assign cnt_en  = (state == RUN) && (cnt_q != len_l);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            gnt    <= '0;
            done   <= '0;
            busy   <= 1'b0;
            len_l  <= '0;
`ifndef COUNTER_SHARE_FIXED_PRIO_EN
            rr_ptr <= PTR_W'(N_REQ - 1);
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= win;
                        len_l  <= len_w;
                        busy   <= 1'b1;
                        state  <= CLR;
`ifndef COUNTER_SHARE_FIXED_PRIO_EN
                        rr_ptr <= widx;
`endif
                    end
                end
                CLR: begin
                    if (!own_req) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                // Abort wins over a same-cycle terminal count: no done pulse.
                RUN: begin
                    if (!own_req) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt_q == len_l) begin
                        done  <= gnt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Scoreboard bench for counter_share_ctrl with a behavioural 4-bit counter.
module tb_counter_share_ctrl;
    import counter_share_pkg::*;

    localparam int N = 4;
    localparam int W = 4;

    logic           clock;
    logic           clear;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic           cnt_clr;
    logic           cnt_en;
    logic [W-1:0]   cnt_q = '0;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int owner;
        int due;
    } exp_t;

    exp_t sb[$];

    counter_share_ctrl #(
        .N_REQ (N),
        .CNT_W (W)
    ) dut (
        .clock   (clock),
        .clear   (clear),
        .req     (req),
        .len     (len),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .cnt_q   (cnt_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (cnt_clr)
            cnt_q <= '0;
        else if (cnt_en)
            cnt_q <= cnt_q + 1'b1;
    end

    task automatic wait_done(input int bound, output bit ok,
                             output int ens, output bit bad_mix,
                             output bit wrapped);
        logic [W-1:0] pq;
        bit           pclr;
        ok      = 1'b0;
        ens     = 0;
        bad_mix = 1'b0;
        wrapped = 1'b0;
        pq      = cnt_q;
        pclr    = cnt_clr;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clock);
            if (cnt_en) ens++;
            if ((cnt_en && cnt_clr) || $countones(gnt) > 1 ||
                $countones(done) > 1)
                bad_mix = 1'b1;
            if (!pclr && cnt_q < pq) wrapped = 1'b1;
            pq   = cnt_q;
            pclr = cnt_clr;
            if (done != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_run_q(input logic [W-1:0] v, input int bound,
                              output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clock);
            if (cnt_en && cnt_q == v) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        req   = '0;
        len   = '0;
        #3 clear = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({gnt, done, busy, cnt_clr, cnt_en} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0",
                     {gnt, done, busy, cnt_clr, cnt_en});
        end
        clear = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0 || gnt !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b gnt=%b want 0/0", busy, gnt);
        end
    endtask

    task automatic test_single();
        bit ok, mix, wr;
        int ens;
        exp_t e;
        req         = 4'b0010;
        len[1*W +: W] = 4'd3;
        sb.push_back('{owner: 1, due: cyc + 6});
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b0010 || cnt_clr !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_grant: gnt=%b clr=%b busy=%b want 0010/1/1",
                     gnt, cnt_clr, busy);
        end
        len[1*W +: W] = 4'd7;
        wait_done(20, ok, ens, mix, wr);
        n_cmp++;
        if (!ok || sb.size() == 0) begin
            n_bad++;
            $display("FAIL single_timeout: done never seen");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (done !== N'(1 << e.owner) || cyc !== e.due) begin
                n_bad++;
                $display("FAIL single_done: done=%b cyc=%0d want %b cyc=%0d",
                         done, cyc, N'(1 << e.owner), e.due);
            end
            n_cmp++;
            if (ens !== 3 || cnt_q !== 4'd3 || mix) begin
                n_bad++;
                $display("FAIL single_count: ens=%0d q=%0d mix=%b want 3/3/0",
                         ens, cnt_q, mix);
            end
        end
        req = '0;
        @(negedge clock);
        n_cmp++;
        if (gnt !== '0 || done !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_release: gnt=%b done=%b busy=%b want 0",
                     gnt, done, busy);
        end
    endtask

    task automatic test_zero_len();
        bit ok, mix, wr;
        int ens;
        exp_t e;
        req         = 4'b0001;
        len[0 +: W] = 4'd0;
        sb.push_back('{owner: 0, due: cyc + 3});
        wait_done(20, ok, ens, mix, wr);
        n_cmp++;
        if (!ok || sb.size() == 0) begin
            n_bad++;
            $display("FAIL zero_timeout: done never seen");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (done !== N'(1 << e.owner) || cyc !== e.due) begin
                n_bad++;
                $display("FAIL zero_done: done=%b cyc=%0d want %b cyc=%0d",
                         done, cyc, N'(1 << e.owner), e.due);
            end
            n_cmp++;
            if (ens !== 0 || cnt_q !== 4'd0) begin
                n_bad++;
                $display("FAIL zero_count: ens=%0d q=%0d want 0/0", ens, cnt_q);
            end
        end
        req = '0;
        @(negedge clock);
    endtask

    task automatic test_round_robin();
        bit ok, mix, wr;
        int ens;
        int base;
        exp_t e;
        clear = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        req   = 4'b1111;
        len   = {4'd1, 4'd1, 4'd1, 4'd1};
        base  = cyc + 4;
        for (int k = 0; k < 5; k++) begin
`ifdef COUNTER_SHARE_FIXED_PRIO_EN
            sb.push_back('{owner: 0, due: base + 5 * k});
`else
            sb.push_back('{owner: k % N, due: base + 5 * k});
`endif
        end
        for (int k = 0; k < 5; k++) begin
            wait_done(20, ok, ens, mix, wr);
            n_cmp++;
            if (!ok || sb.size() == 0) begin
                n_bad++;
                $display("FAIL rr_timeout: grant %0d never completed", k);
                break;
            end
            e = sb.pop_front();
            n_cmp++;
            if (done !== N'(1 << e.owner) || cyc !== e.due || mix) begin
                n_bad++;
                $display("FAIL rr_done%0d: done=%b cyc=%0d mix=%b want %b cyc=%0d",
                         k, done, cyc, mix, N'(1 << e.owner), e.due);
            end
        end
        req = '0;
        @(negedge clock);
        sb.delete();
    endtask

    task automatic test_abort();
        bit ok;
        bit seen_done;
        req           = 4'b0100;
        len[2*W +: W] = 4'd9;
        len[1*W +: W] = 4'd2;
        wait_run_q(4'd4, 30, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL abort_reach: cnt_q=4 never reached in RUN");
        end
        req = '0;
        @(negedge clock);
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b0 || cnt_en !== 1'b0 ||
            done !== '0) begin
            n_bad++;
            $display("FAIL abort_idle: gnt=%b busy=%b en=%b done=%b want 0",
                     gnt, busy, cnt_en, done);
        end
        req = 4'b0110;
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL abort_next_grant: gnt=%b want 0010", gnt);
        end
        req = '0;
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done !== '0) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done || gnt !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_clr: done_seen=%b gnt=%b busy=%b want 0",
                     seen_done, gnt, busy);
        end
    endtask

    task automatic test_max_len();
        bit ok, mix, wr;
        int ens;
        exp_t e;
        req         = 4'b0001;
        len[0 +: W] = 4'd15;
        sb.push_back('{owner: 0, due: cyc + 18});
        wait_done(40, ok, ens, mix, wr);
        n_cmp++;
        if (!ok || sb.size() == 0) begin
            n_bad++;
            $display("FAIL max_timeout: done never seen");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (done !== N'(1 << e.owner) || cyc !== e.due) begin
                n_bad++;
                $display("FAIL max_done: done=%b cyc=%0d want %b cyc=%0d",
                         done, cyc, N'(1 << e.owner), e.due);
            end
            n_cmp++;
            if (ens !== 15 || cnt_q !== 4'd15 || wr || mix) begin
                n_bad++;
                $display("FAIL max_count: ens=%0d q=%0d wrap=%b mix=%b want 15/15/0/0",
                         ens, cnt_q, wr, mix);
            end
        end
        req = '0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        req         = 4'b0001;
        len[0 +: W] = 4'd9;
        wait_run_q(4'd5, 30, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rst_reach: cnt_q=5 never reached in RUN");
        end
        #2 clear = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, done, busy, cnt_clr, cnt_en} !== '0) begin
            n_bad++;
            $display("FAIL rst_async: got %b want 0",
                     {gnt, done, busy, cnt_clr, cnt_en});
        end
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b0001 || cnt_clr !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_regrant: gnt=%b clr=%b want 0001/1", gnt, cnt_clr);
        end
        req = '0;
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_round_robin();
        test_abort();
        test_max_len();
        test_reset_mid_run();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
